// File: rtl/id_ex_pipe_ctrl.sv
// rtl/id_ex_pipe_ctrl.sv - ID/EX pipeline register with stall/flush control
// Bubbles on flush, load-use hazard or empty ID; tracks stall/flush counts and stall-length watchdog.
module id_ex_pipe_ctrl #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 2
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             ID_valid,
    input  logic [31:0]      ID_pc,
    input  logic [31:0]      ID_pc4,
    input  logic [31:0]      ID_ext,
    input  logic [31:0]      ID_rD1,
    input  logic [31:0]      ID_rD2,
    input  logic [4:0]       ID_wR,
    input  logic             ID_rf_we,
    input  logic [1:0]       ID_rf_wsel,
    input  logic [3:0]       ID_alu_op,
    input  logic             ID_alub_sel,
    input  logic             ID_dram_we,
    input  logic             ID_branch,
    input  logic             ID_jump,
    input  logic             data_hazard,
    input  logic             EX_flush,
    output logic             EX_valid,
    output logic [31:0]      EX_pc,
    output logic [31:0]      EX_pc4,
    output logic [31:0]      EX_ext,
    output logic [31:0]      EX_rD1,
    output logic [31:0]      EX_rD2,
    output logic [4:0]       EX_wR,
    output logic             EX_rf_we,
    output logic [1:0]       EX_rf_wsel,
    output logic [3:0]       EX_alu_op,
    output logic             EX_alub_sel,
    output logic             EX_dram_we,
    output logic             EX_branch,
    output logic             EX_jump,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hazard_err
);

    localparam int              RUN_W   = $clog2(MAX_STALL) + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic             stall_now;
    logic             bubble;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;

    // A flush squashes the instruction that would otherwise be stalled.
    assign stall_now  = data_hazard & ~EX_flush;
    assign bubble     = EX_flush | data_hazard | ~ID_valid;
    assign pc_stall   = ~cpu_rst & stall_now;
    assign ifid_stall = ~cpu_rst & stall_now;
    assign ifid_flush = ~cpu_rst & EX_flush;

    always_comb begin
        run_next = '0;
        if (stall_now) begin
            run_next = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || bubble) begin
            EX_valid    <= 1'b0;
            EX_pc       <= '0;
            EX_pc4      <= '0;
            EX_ext      <= '0;
            EX_rD1      <= '0;
            EX_rD2      <= '0;
            EX_wR       <= '0;
            EX_rf_we    <= 1'b0;
            EX_rf_wsel  <= '0;
            EX_alu_op   <= '0;
            EX_alub_sel <= 1'b0;
            EX_dram_we  <= 1'b0;
            EX_branch   <= 1'b0;
            EX_jump     <= 1'b0;
        end else begin
            EX_valid    <= 1'b1;
            EX_pc       <= ID_pc;
            EX_pc4      <= ID_pc4;
            EX_ext      <= ID_ext;
            EX_rD1      <= ID_rD1;
            EX_rD2      <= ID_rD2;
            EX_wR       <= ID_wR;
            EX_rf_we    <= ID_rf_we;
            EX_rf_wsel  <= ID_rf_wsel;
            EX_alu_op   <= ID_alu_op;
            EX_alub_sel <= ID_alub_sel;
            EX_dram_we  <= ID_dram_we;
            EX_branch   <= ID_branch;
            EX_jump     <= ID_jump;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            run_cnt    <= '0;
            hazard_err <= 1'b0;
        end else begin
            if (stall_now && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (EX_flush && flush_cnt != {CNT_W{1'b1}}) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            run_cnt    <= run_next;
            hazard_err <= hazard_err | (run_next == RUN_MAX);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_ctrl.sv
// tb/tb_id_ex_pipe_ctrl.sv - self-checking bench for id_ex_pipe_ctrl
// Directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_id_ex_pipe_ctrl;

    localparam int CNT_W     = 4;
    localparam int MAX_STALL = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic cpu_clk = 1'b0;
    logic cpu_rst;
    logic ID_valid, ID_rf_we, ID_alub_sel, ID_dram_we, ID_branch, ID_jump;
    logic [31:0] ID_pc, ID_pc4, ID_ext, ID_rD1, ID_rD2;
    logic [4:0]  ID_wR;
    logic [1:0]  ID_rf_wsel;
    logic [3:0]  ID_alu_op;
    logic data_hazard, EX_flush;

    logic EX_valid, EX_rf_we, EX_alub_sel, EX_dram_we, EX_branch, EX_jump;
    logic [31:0] EX_pc, EX_pc4, EX_ext, EX_rD1, EX_rD2;
    logic [4:0]  EX_wR;
    logic [1:0]  EX_rf_wsel;
    logic [3:0]  EX_alu_op;
    logic pc_stall, ifid_stall, ifid_flush, hazard_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    id_ex_pipe_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_pc4(ID_pc4), .ID_ext(ID_ext),
        .ID_rD1(ID_rD1), .ID_rD2(ID_rD2), .ID_wR(ID_wR), .ID_rf_we(ID_rf_we),
        .ID_rf_wsel(ID_rf_wsel), .ID_alu_op(ID_alu_op), .ID_alub_sel(ID_alub_sel),
        .ID_dram_we(ID_dram_we), .ID_branch(ID_branch), .ID_jump(ID_jump),
        .data_hazard(data_hazard), .EX_flush(EX_flush),
        .EX_valid(EX_valid), .EX_pc(EX_pc), .EX_pc4(EX_pc4), .EX_ext(EX_ext),
        .EX_rD1(EX_rD1), .EX_rD2(EX_rD2), .EX_wR(EX_wR), .EX_rf_we(EX_rf_we),
        .EX_rf_wsel(EX_rf_wsel), .EX_alu_op(EX_alu_op), .EX_alub_sel(EX_alub_sel),
        .EX_dram_we(EX_dram_we), .EX_branch(EX_branch), .EX_jump(EX_jump),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hazard_err(hazard_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: the instruction word EX should hold, plus counters.
    logic        m_valid;
    logic [31:0] m_pc, m_pc4, m_ext, m_rD1, m_rD2;
    logic [16:0] m_ctrl;
    int          m_stalls, m_flushes, m_run;
    logic        m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] id_ctrl();
        return {ID_wR, ID_rf_we, ID_rf_wsel, ID_alu_op, ID_alub_sel, ID_dram_we, ID_branch, ID_jump};
    endfunction

    task automatic model_update();
        bit stall;
        stall = data_hazard && !EX_flush;
        if (cpu_rst) begin
            m_valid = 0; m_pc = 0; m_pc4 = 0; m_ext = 0; m_rD1 = 0; m_rD2 = 0; m_ctrl = 0;
            m_stalls = 0; m_flushes = 0; m_run = 0; m_err = 0;
        end else begin
            if (EX_flush || data_hazard || !ID_valid) begin
                m_valid = 0; m_pc = 0; m_pc4 = 0; m_ext = 0; m_rD1 = 0; m_rD2 = 0; m_ctrl = 0;
            end else begin
                m_valid = 1; m_pc = ID_pc; m_pc4 = ID_pc4; m_ext = ID_ext;
                m_rD1 = ID_rD1; m_rD2 = ID_rD2; m_ctrl = id_ctrl();
            end
            if (stall) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
            if (EX_flush) m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
            m_run = stall ? m_run + 1 : 0;
            if (m_run >= MAX_STALL) m_err = 1;
        end
    endtask

    // One clock: check combinational controls mid-cycle, then registered state after the edge.
    task automatic step();
        bit exp_stall;
        @(negedge cpu_clk);
        exp_stall = !cpu_rst && data_hazard && !EX_flush;
        chk("pc_stall", 64'(pc_stall), 64'(exp_stall));
        chk("ifid_stall", 64'(ifid_stall), 64'(exp_stall));
        chk("ifid_flush", 64'(ifid_flush), 64'(!cpu_rst && EX_flush));
        model_update();
        @(posedge cpu_clk);
        #1;
        chk("EX_valid", 64'(EX_valid), 64'(m_valid));
        chk("EX_pc", 64'(EX_pc), 64'(m_pc));
        chk("EX_pc4", 64'(EX_pc4), 64'(m_pc4));
        chk("EX_ext", 64'(EX_ext), 64'(m_ext));
        chk("EX_rD1", 64'(EX_rD1), 64'(m_rD1));
        chk("EX_rD2", 64'(EX_rD2), 64'(m_rD2));
        chk("EX_ctrl", 64'({EX_wR, EX_rf_we, EX_rf_wsel, EX_alu_op, EX_alub_sel,
                            EX_dram_we, EX_branch, EX_jump}), 64'(m_ctrl));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stalls));
        chk("flush_cnt", 64'(flush_cnt), 64'(m_flushes));
        chk("hazard_err", 64'(hazard_err), 64'(m_err));
    endtask

    task automatic rand_id();
        ID_valid = ($urandom_range(0, 7) != 0);
        ID_pc = $urandom; ID_pc4 = $urandom; ID_ext = $urandom;
        ID_rD1 = $urandom; ID_rD2 = $urandom;
        ID_wR = 5'($urandom); ID_rf_we = 1'($urandom); ID_rf_wsel = 2'($urandom);
        ID_alu_op = 4'($urandom); ID_alub_sel = 1'($urandom); ID_dram_we = 1'($urandom);
        ID_branch = 1'($urandom); ID_jump = 1'($urandom);
    endtask

    task automatic clear_id();
        ID_valid = 0; ID_pc = 0; ID_pc4 = 0; ID_ext = 0; ID_rD1 = 0; ID_rD2 = 0;
        ID_wR = 0; ID_rf_we = 0; ID_rf_wsel = 0; ID_alu_op = 0; ID_alub_sel = 0;
        ID_dram_we = 0; ID_branch = 0; ID_jump = 0;
    endtask

    initial begin
        cpu_rst = 1; data_hazard = 0; EX_flush = 0;
        clear_id();
        step();
        step();
        cpu_rst = 0;

        ID_valid = 1; ID_pc = 32'h100; ID_rD1 = 32'hA5A5A5A5; ID_rf_we = 1; ID_wR = 5;
        step();
        chk("first_pc", 64'(EX_pc), 64'h100);
        chk("first_rD1", 64'(EX_rD1), 64'hA5A5A5A5);
        chk("first_wR", 64'(EX_wR), 64'd5);

        ID_pc = 32'h200; data_hazard = 1;
        step();
        chk("stall_bubble", 64'(EX_valid), 64'd0);
        data_hazard = 0;
        step();
        chk("after_stall_pc", 64'(EX_pc), 64'h200);
        chk("stall_cnt_1", 64'(stall_cnt), 64'd1);
        chk("no_err_1cyc", 64'(hazard_err), 64'd0);

        ID_dram_we = 1; EX_flush = 1;
        step();
        chk("flush_dram_we", 64'(EX_dram_we), 64'd0);
        chk("flush_cnt_1", 64'(flush_cnt), 64'd1);

        data_hazard = 1;
        step();
        chk("both_stall_cnt", 64'(stall_cnt), 64'd1);
        chk("both_flush_cnt", 64'(flush_cnt), 64'd2);
        EX_flush = 0;

        step();
        step();
        chk("err_after_2", 64'(hazard_err), 64'd1);
        data_hazard = 0;
        step();
        chk("err_sticky", 64'(hazard_err), 64'd1);
        cpu_rst = 1;
        step();
        chk("err_reset", 64'(hazard_err), 64'd0);
        cpu_rst = 0;

        for (int i = 0; i < 40; i++) begin
            data_hazard = (i % 2 == 0);
            rand_id();
            step();
        end
        chk("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));

        // Reset in the middle of a stall, then resume normally.
        data_hazard = 1;
        step();
        cpu_rst = 1;
        step();
        cpu_rst = 0; data_hazard = 0;
        rand_id(); ID_valid = 1;
        step();
        chk("post_rst_valid", 64'(EX_valid), 64'd1);

        for (int i = 0; i < 400; i++) begin
            rand_id();
            cpu_rst = ($urandom_range(0, 59) == 0);
            if (data_hazard) data_hazard = ($urandom_range(0, 2) == 0);
            else             data_hazard = ($urandom_range(0, 4) == 0);
            EX_flush = ($urandom_range(0, 7) == 0);
            step();
        end
        EX_flush = 0;
        for (int i = 0; i < 20; i++) begin
            EX_flush = 1;
            step();
        end
        chk("flush_sat", 64'(flush_cnt), 64'(CNT_MAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe_ctrl.md
Name: id_ex_pipe_ctrl

Overview:
ID/EX pipeline register combined with pipeline stall/flush control. It sits directly downstream of the data hazard detection unit. It consumes that unit's forwarded operands and its load-use stall flag, and registers the decoded instruction into the EX stage. On a stall it inserts a bubble, on a taken branch or jump it squashes the instruction, and it drives the PC and IF/ID stall/flush controls. It also keeps saturating stall/flush performance counters and a stall-length watchdog.

Parameters:
CNT_W, 32, width of the stall and flush performance counters.
MAX_STALL, 2, number of consecutive stall cycles after which hazard_err is raised.

Ports:
cpu_clk  in  1  clock; all state updates on the rising edge.
cpu_rst  in  1  synchronous, active-high reset.
ID_valid  in  1  ID holds a real instruction.
ID_pc  in  32  PC of the ID instruction.
ID_pc4  in  32  PC+4.
ID_ext  in  32  sign-extended immediate.
ID_rD1  in  32  forwarded operand 1 (new_rD1 from the hazard unit).
ID_rD2  in  32  forwarded operand 2 (new_rD2 from the hazard unit).
ID_wR  in  5  destination register.
ID_rf_we  in  1  register-file write enable.
ID_rf_wsel  in  2  writeback source select (S_PC4/S_SEXT_ext/S_ALU_C/S_DRAM_rd).
ID_alu_op  in  4  ALU operation.
ID_alub_sel  in  1  ALU B select (0 = rD2, 1 = ext).
ID_dram_we  in  1  data memory write enable.
ID_branch  in  1  conditional branch.
ID_jump  in  1  unconditional jump.
data_hazard  in  1  load-use stall request from the hazard unit.
EX_flush  in  1  taken branch or jump resolved in EX; squash ID and IF.
EX_valid  out  1  EX holds a real instruction.
EX_pc, EX_pc4, EX_ext, EX_rD1, EX_rD2  out  32 each  registered copies of the ID fields.
EX_wR  out  5  registered copy of ID_wR.
EX_rf_we  out  1  registered copy of ID_rf_we.
EX_rf_wsel  out  2  registered copy of ID_rf_wsel.
EX_alu_op  out  4  registered copy of ID_alu_op.
EX_alub_sel  out  1  registered copy of ID_alub_sel.
EX_dram_we  out  1  registered copy of ID_dram_we.
EX_branch  out  1  registered copy of ID_branch.
EX_jump  out  1  registered copy of ID_jump.
pc_stall  out  1  hold the PC (combinational).
ifid_stall  out  1  hold the IF/ID register (combinational).
ifid_flush  out  1  clear the IF/ID register (combinational).
stall_cnt  out  CNT_W  cycles in which a bubble was inserted for a hazard.
flush_cnt  out  CNT_W  cycles in which ID was squashed.
hazard_err  out  1  sticky flag: stall ran MAX_STALL or more consecutive cycles.

Behaviour:
- Reset (cpu_rst=1 at an edge): all EX_* registers, both counters, the run counter and hazard_err go to 0. pc_stall, ifid_stall and ifid_flush are forced to 0 while cpu_rst=1.
- Combinational controls:
  - ifid_flush = EX_flush.
  - pc_stall = ifid_stall = data_hazard & ~EX_flush. A flush overrides a stall, because the stalled instruction is being squashed.
- Register update priority, highest first:
  1. reset;
  2. EX_flush: bubble;
  3. data_hazard: bubble;
  4. ~ID_valid: bubble;
  5. otherwise load every ID_* field into EX_* and set EX_valid=1.
- Bubble: EX_valid, EX_rf_we, EX_dram_we, EX_branch and EX_jump = 0. All other EX_* fields = 0. A bubble never writes the register file or memory.
- Latency: 1 cycle from ID to EX. A stalled instruction stays in ID and is captured on the first edge where data_hazard=0.
- stall_cnt increments by 1 on each edge with data_hazard=1 and EX_flush=0.
- flush_cnt increments on each edge with EX_flush=1.
- Both counters saturate at 2^CNT_W-1 and never wrap.
- Run counter (width clog2(MAX_STALL)+1):
  - increments on each edge with pc_stall=1 and saturates at MAX_STALL;
  - clears on any edge with pc_stall=0;
  - hazard_err sets when the run counter reaches MAX_STALL and stays set until reset.
  - A correct load-use stall lasts exactly 1 cycle, so hazard_err stays 0 in normal operation.
- Simultaneous data_hazard and EX_flush: bubble, no stall, flush_cnt increments, stall_cnt does not.
- Reset asserted mid-stall: run counter and hazard_err clear; the next instruction after reset is captured normally.

Test Plan:
- Reset, then ID_valid=1, ID_pc=0x100, ID_rD1=0xA5A5A5A5, ID_rf_we=1, ID_wR=5 -> next edge: EX_valid=1, EX_pc=0x100, EX_rD1=0xA5A5A5A5, EX_wR=5, EX_rf_we=1.
- data_hazard=1 for 1 cycle with ID_pc=0x200 -> pc_stall=ifid_stall=1 that cycle; EX bubble (EX_valid=0, EX_rf_we=0); next edge EX_pc=0x200; stall_cnt=1; hazard_err=0.
- EX_flush=1 with ID_valid=1 and ID_dram_we=1 -> ifid_flush=1; EX_valid=0, EX_dram_we=0; flush_cnt=1.
- data_hazard=1 and EX_flush=1 together -> pc_stall=0, ifid_flush=1; flush_cnt +1; stall_cnt unchanged.
- data_hazard held 2 cycles (MAX_STALL=2) -> hazard_err=1 after the 2nd edge; it stays 1 after data_hazard drops; cpu_rst=1 clears it to 0.
- CNT_W=4, data_hazard toggled so that 20 stall cycles occur -> stall_cnt stops at 15 and never wraps.
